bitpacker_scheduler: RTL
========================

// Module: bitpacker_scheduler
//
// PURPOSE
//   Shares one 32-bit bitpacker between NUM_REQ variable-length code producers (e.g. Y/Cb/Cr
//   huffman encoders) using round-robin arbitration. Tracks the packer's fill level mod 32.
//   Sequences the end-of-scan flush: pads the partial word with 1-bits so the packer emits it,
//   then reports how many bytes of that last word are real. Sits between encoders and bitpacker.
//
// PARAMETERS
//   NUM_REQ  3  number of requesters (1..8)
//
// PORTS
//   clock             in   1          system clock, all logic on rising edge
//   reset             in   1          asynchronous, active-high; clears all state
//   req_valid         in   NUM_REQ    requester i has a code on req_data/req_length slice i
//   req_data          in   32*NUM_REQ code bits, LSB-first; slice i = [32*i+31:32*i]
//   req_length        in   6*NUM_REQ  code length 0..32; slice i = [6*i+5:6*i]
//   req_ready         out  NUM_REQ    one-hot grant; transfer when valid&ready same cycle
//   flush_req         in   1          single-cycle pulse: pad and close current word
//   flush_done        out  1          single-cycle pulse: final word has left the bitpacker
//   last_word_bytes   out  3          valid with flush_done: 0..4 meaningful bytes in final word
//   pk_valid          out  1          to bitpacker data_in_valid
//   pk_data           out  32         to bitpacker data_in
//   pk_length         out  6          to bitpacker input_length
//   length_error      out  1          sticky: a granted request had length > 32
//
// BEHAVIOUR
//   Reset: req_ready=0, pk_valid=0, pk_data=0, pk_length=0, flush_done=0, last_word_bytes=0,
//     length_error=0, fill=0, rr pointer=0, state=RUN.
//   pk_length MUST be 0 whenever pk_valid=0 (the bitpacker accumulates length unconditionally).
//   States: RUN -> (flush_req) DRAIN -> PAD -> WAIT1 -> WAIT2 -> DONE -> RUN.
//   RUN: req_ready combinational = one-hot of first valid requester at/after rr pointer
//     (wrapping NUM_REQ-1 -> 0); zero when none valid. On transfer, pk_* registered next cycle
//     (latency 1); pointer <= granted+1 mod NUM_REQ; fill <= (fill + len) mod 32 (5-bit wrap).
//     Length 0: transfer accepted, pk_valid=1, pk_length=0, fill unchanged.
//     Length 33..63: transfer accepted, code dropped (pk_valid=0, length 0), length_error<=1.
//   flush_req in RUN: no grant that cycle or after until return to RUN; state<=DRAIN.
//     flush_req in any other state is ignored.
//   DRAIN (1 cycle, lets last registered code land): if fill==0 -> DONE with last_word_bytes=0,
//     no pad issued; else -> PAD.
//   PAD: pk_valid=1, pk_data=32'hFFFF_FFFF, pk_length=32-fill; last_word_bytes<=ceil(fill/8);
//     fill<=0. WAIT1/WAIT2 cover pk register + bitpacker output register latency.
//   DONE: flush_done=1 one cycle, last_word_bytes held until next flush; -> RUN.
//   Flush latency: flush_req to flush_done = 5 cycles with pad, 2 cycles when fill==0.
//   Reset asserted mid-flush or mid-transfer: all state cleared immediately; the in-flight
//     code is lost; bitpacker shares the reset so its accumulator is consistent with fill=0.
//   Simultaneous flush_req and grant in RUN: flush wins, no grant that cycle.
//
// STRUCTURE
//   Shared package jfpjc_pkg: WORD_BITS=32, LEN_W=6, PAD_PATTERN=32'hFFFF_FFFF,
//     scheduler state encoding (RUN, DRAIN, PAD, WAIT1, WAIT2, DONE).
//   One sub-module: rr_arbiter (NUM_REQ param; req vector + pointer in, one-hot grant out).
//   Top holds FSM, fill counter, pk_* output registers, length_error flag.
//
// TESTING (bench instantiates bitpacker_scheduler + bitpacker, NUM_REQ=3)
//   All 3 valid continuously, len 8 each, data 8'hA0/8'hB1/8'hC2 -> grants 0,1,2,0 in order;
//     after 4 codes one bitpacker word 32'hA0C2B1A0.
//   Req1 alone, len 5 x6 (fill=30) then flush_req -> pad len 2 of 1s, flush_done 5 cycles
//     later, last_word_bytes=4, final word bits [31:30]=2'b11.
//   fill==0 then flush_req -> no pk_valid, flush_done 2 cycles later, last_word_bytes=0.
//   Req0 len 40 -> transfer accepted, pk_valid stays 0, length_error=1 and stays 1; fill unchanged.
//   Len 20 then len 20 -> fill wraps to 8, bitpacker emits word; flush -> pad 24, bytes=1.
//   reset asserted during WAIT1 -> all outputs 0 next edge, no flush_done ever for that flush.

Source files
------------

// File: rtl/jfpjc_pkg.sv
// Shared constants and scheduler state encoding for the bitpacker front end.
package jfpjc_pkg;

   localparam int          WORD_BITS   = 32;
   localparam int          LEN_W       = 6;
   localparam int          FILL_W      = 5;
   localparam logic [31:0] PAD_PATTERN = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_DRAIN,
      ST_PAD,
      ST_WAIT1,
      ST_WAIT2,
      ST_DONE
   } sched_state_t;

endpackage

// File: rtl/bitpacker_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first request at or after ptr.
module rr_arbiter
   import jfpjc_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx
);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/bitpacker_scheduler.sv
// Round-robin sharing of one 32-bit bitpacker, fill tracking mod 32 and end-of-scan pad/flush.
module bitpacker_scheduler
   import jfpjc_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [32*NUM_REQ-1:0]  req_data,
   input  logic [6*NUM_REQ-1:0]   req_length,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic                   flush_req,
   output logic                   flush_done,
   output logic [2:0]             last_word_bytes,
   output logic                   pk_valid,
   output logic [31:0]            pk_data,
   output logic [5:0]             pk_length,
   output logic                   length_error
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_t               state, state_nxt;
   logic [PTR_W-1:0]           rr_ptr, grant_idx;
   logic [NUM_REQ-1:0]         grant;
   logic [FILL_W-1:0]          fill;
   logic                       xfer;
   logic [WORD_BITS-1:0]       sel_data;
   logic [LEN_W-1:0]           sel_len;
   logic                       pk_vld_p1;
   logic [WORD_BITS-1:0]       pk_data_p1;
   logic [LEN_W-1:0]           pk_len_p1;

   function automatic logic [2:0] bytes_used(input logic [FILL_W-1:0] f);
      logic [5:0] r;
      r = {1'b0, f} + 6'd7;
      return r[5:3];
   endfunction

   function automatic logic [LEN_W-1:0] pad_len(input logic [FILL_W-1:0] f);
      return 6'd32 - {1'b0, f};
   endfunction

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // A flush request blocks the grant in the same cycle so the drain sees a stable fill.
   assign req_ready = (state == ST_RUN && !flush_req) ? grant : '0;
   assign xfer      = |(req_valid & req_ready);
   assign sel_data  = req_data[WORD_BITS*int'(grant_idx) +: WORD_BITS];
   assign sel_len   = req_length[LEN_W*int'(grant_idx) +: LEN_W];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (flush_req) state_nxt = ST_DRAIN;
         ST_DRAIN: state_nxt = (fill == '0) ? ST_DONE : ST_PAD;
         ST_PAD:   state_nxt = ST_WAIT1;
         ST_WAIT1: state_nxt = ST_WAIT2;
         ST_WAIT2: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // p1: registered packer drive; length forced to 0 whenever nothing is presented
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr          <= '0;
         fill            <= '0;
         pk_vld_p1       <= 1'b0;
         pk_data_p1      <= '0;
         pk_len_p1       <= '0;
         last_word_bytes <= '0;
         length_error    <= 1'b0;
      end else begin
         pk_vld_p1  <= 1'b0;
         pk_data_p1 <= '0;
         pk_len_p1  <= '0;
         if (xfer) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
            if (sel_len > 6'd32) begin
               length_error <= 1'b1;
            end else begin
               pk_vld_p1  <= 1'b1;
               pk_data_p1 <= sel_data;
               pk_len_p1  <= sel_len;
               fill       <= fill + sel_len[FILL_W-1:0];
            end
         end
         if (state == ST_DRAIN) begin
            if (fill == '0) begin
               last_word_bytes <= '0;
            end else begin
               pk_vld_p1       <= 1'b1;
               pk_data_p1      <= PAD_PATTERN;
               pk_len_p1       <= pad_len(fill);
               last_word_bytes <= bytes_used(fill);
               fill            <= '0;
            end
         end
      end
   end

   assign pk_valid   = pk_vld_p1;
   assign pk_data    = pk_data_p1;
   assign pk_length  = pk_len_p1;
   assign flush_done = (state == ST_DONE);

endmodule
